// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream writer for the 80x60 text-mode VRAM.
//   Accepts bytes over a valid/ready handshake, prints cells, handles control
//   codes (LF, CR, BS, FF), tracks the cursor and clears/scrolls the screen.
// Optional feature: define TEXT_AUTO_SCROLL_EN to scroll the screen on row
//   overflow (VRAM read-back and rewrite). Undefined, the cursor wraps to 0,0.
// Ports:
//   clk, rst (synchronous, active low)
//   char_in/color_in/char_valid/char_ready : input byte handshake
//   vram_waddr/vram_wdata/vram_wen         : VRAM write port, cell {colour,0,ascii}
//   vram_raddr/vram_rdata                  : VRAM read port, one-cycle latency
//   Cursor                                 : {row[5:0], col[6:0]}
//   busy                                   : inverse of char_ready
module text_console_writer #(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 60,
  parameter logic [2:0]  BLANK_COLOR = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic [2:0]  color_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [12:0] vram_waddr,
  output logic [10:0] vram_wdata,
  output logic        vram_wen,
  output logic [12:0] vram_raddr,
  input  logic [10:0] vram_rdata,
  output logic [12:0] Cursor,
  output logic        busy
);

  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = 11;
  localparam int unsigned RW    = 6;
  localparam int unsigned CW    = 7;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam logic [DW-1:0] BLANK = {BLANK_COLOR, 1'b0, 7'h20};

  typedef enum logic [2:0] {
    S_CLEAR_ALL,
    S_IDLE,
    S_WRITE,
    S_BKSP,
    S_SCROLL_RD,
    S_SCROLL_WR,
    S_SCROLL_FILL
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [6:0]    code;
  logic          last_row;
  logic          last_col;
`ifdef TEXT_AUTO_SCROLL_EN
  logic [AW-1:0] raddr_q, raddr_d;
  logic          pend_q, pend_d;
`else
  logic          unused_rdata;
`endif

  // Linear cell address, constant multiply by COLS.
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  // Next-state, cursor and write-port computation. Write outputs are set up
  // one cycle ahead so the strobe is visible during the state that owns it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
`ifdef TEXT_AUTO_SCROLL_EN
    raddr_d  = raddr_q;
    pend_d   = pend_q;
`endif
    code     = char_in[6:0];
    last_row = (row_q == RW'(ROWS - 1));
    last_col = (col_q == CW'(COLS - 1));

    case (state_q)
      // Counter holds the next address to blank; reaching CELLS means done.
      S_CLEAR_ALL: begin
        if (cnt_q == AW'(CELLS)) begin
          state_d = S_IDLE;
          row_d   = '0;
          col_d   = '0;
        end else begin
          wen_d   = 1'b1;
          waddr_d = cnt_q;
          wdata_d = BLANK;
          cnt_d   = cnt_q + AW'(1);
        end
      end

      S_IDLE: begin
        if (char_valid && ready_q) begin
          if (code >= 7'h20 && code <= 7'h7E) begin
            state_d = S_WRITE;
            wen_d   = 1'b1;
            waddr_d = cell_addr(row_q, col_q);
            wdata_d = {color_in, 1'b0, code};
            if (!last_col) begin
              col_d = col_q + CW'(1);
            end else begin
              col_d = '0;
              if (!last_row) begin
                row_d = row_q + RW'(1);
              end else begin
`ifdef TEXT_AUTO_SCROLL_EN
                pend_d = 1'b1;
`else
                row_d = '0;
`endif
              end
            end
          end else begin
            case (code)
              7'h0A: begin
                col_d = '0;
                if (!last_row) begin
                  row_d = row_q + RW'(1);
                end else begin
`ifdef TEXT_AUTO_SCROLL_EN
                  state_d = S_SCROLL_RD;
                  cnt_d   = AW'(COLS);
                  raddr_d = AW'(COLS);
`else
                  row_d = '0;
`endif
                end
              end
              7'h0D: col_d = '0;
              7'h08: begin
                if (col_q != '0) begin
                  state_d = S_BKSP;
                  col_d   = col_q - CW'(1);
                  wen_d   = 1'b1;
                  waddr_d = cell_addr(row_q, col_q - CW'(1));
                  wdata_d = BLANK;
                end
              end
              // First blank is issued right away so the clear takes CELLS cycles.
              7'h0C: begin
                state_d = S_CLEAR_ALL;
                cnt_d   = AW'(1);
                wen_d   = 1'b1;
                waddr_d = '0;
                wdata_d = BLANK;
              end
              default: ;
            endcase
          end
        end
      end

      S_WRITE: begin
`ifdef TEXT_AUTO_SCROLL_EN
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = S_SCROLL_RD;
          cnt_d   = AW'(COLS);
          raddr_d = AW'(COLS);
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_BKSP: state_d = S_IDLE;

`ifdef TEXT_AUTO_SCROLL_EN
      // raddr is already on the bus; arm the write for the following cycle.
      S_SCROLL_RD: begin
        state_d = S_SCROLL_WR;
        wen_d   = 1'b1;
        waddr_d = cnt_q - AW'(COLS);
      end

      S_SCROLL_WR: begin
        if (cnt_q == AW'(CELLS - 1)) begin
          state_d = S_SCROLL_FILL;
          cnt_d   = AW'(CELLS - COLS);
          wen_d   = 1'b1;
          waddr_d = AW'(CELLS - COLS);
          wdata_d = BLANK;
        end else begin
          state_d = S_SCROLL_RD;
          cnt_d   = cnt_q + AW'(1);
          raddr_d = cnt_q + AW'(1);
        end
      end

      S_SCROLL_FILL: begin
        if (cnt_q == AW'(CELLS - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + AW'(1);
          wen_d   = 1'b1;
          waddr_d = cnt_q + AW'(1);
          wdata_d = BLANK;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_CLEAR_ALL;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
`ifdef TEXT_AUTO_SCROLL_EN
      raddr_q <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef TEXT_AUTO_SCROLL_EN
      raddr_q <= raddr_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign char_ready = ready_q;
  assign busy       = busy_q;
  assign vram_wen   = wen_q;
  assign vram_waddr = waddr_q;
  assign Cursor     = {row_q, col_q};

`ifdef TEXT_AUTO_SCROLL_EN
  // Read data is forwarded straight to the write port while copying so each
  // moved cell costs exactly one read cycle plus one write cycle.
  assign vram_wdata = (state_q == S_SCROLL_WR) ? vram_rdata : wdata_q;
  assign vram_raddr = raddr_q;
`else
  assign vram_wdata   = wdata_q;
  assign vram_raddr   = '0;
  assign unused_rdata = ^vram_rdata;
`endif

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 60;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam logic [10:0] BLANK = 11'h720;
`ifdef TEXT_AUTO_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  char_in;
  logic [2:0]  color_in;
  logic        char_valid;
  logic        char_ready;
  logic [12:0] vram_waddr;
  logic [10:0] vram_wdata;
  logic        vram_wen;
  logic [12:0] vram_raddr;
  logic [10:0] vram_rdata;
  logic [12:0] Cursor;
  logic        busy;

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .color_in   (color_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_wen   (vram_wen),
    .vram_raddr (vram_raddr),
    .vram_rdata (vram_rdata),
    .Cursor     (Cursor),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM with synchronous read, one-cycle latency.
  logic [10:0] mem [CELLS];
  logic [10:0] rdata_q = '0;
  always @(posedge clk) begin
    if (vram_wen && vram_waddr < 13'(CELLS)) mem[vram_waddr] <= vram_wdata;
    rdata_q <= (vram_raddr < 13'(CELLS)) ? mem[vram_raddr] : 11'h0;
  end
  assign vram_rdata = rdata_q;

  // Protocol monitors.
  int idle_wen_bad = 0;
  int busy_bad     = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (vram_wen && char_ready) idle_wen_bad++;
      if (busy !== ~char_ready) busy_bad++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: screen image and cursor.
  logic [10:0] scr [CELLS];
  int m_row = 0;
  int m_col = 0;

  function automatic void model_clear();
    for (int i = 0; i < int'(CELLS); i++) scr[i] = BLANK;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void model_scroll();
    for (int i = 0; i < int'(CELLS - COLS); i++) scr[i] = scr[i + int'(COLS)];
    for (int i = int'(CELLS - COLS); i < int'(CELLS); i++) scr[i] = BLANK;
  endfunction

  // Moves to the next row; returns 1 when a scroll happens.
  function automatic bit model_next_row();
    m_col = 0;
    if (m_row < int'(ROWS) - 1) begin
      m_row++;
      return 1'b0;
    end
    if (SCROLL) begin
      model_scroll();
      return 1'b1;
    end
    m_row = 0;
    return 1'b0;
  endfunction

  task automatic model_step(input logic [7:0] ch, input logic [2:0] col,
                            output int e_low, output int e_nwr,
                            output int e_addr, output logic [10:0] e_data);
    logic [6:0] c;
    c = ch[6:0];
    e_low = 0; e_nwr = 0; e_addr = 0; e_data = '0;
    if (c >= 7'h20 && c <= 7'h7E) begin
      e_addr = m_row * int'(COLS) + m_col;
      e_data = {col, 1'b0, c};
      scr[e_addr] = e_data;
      e_low = 1; e_nwr = 1;
      if (m_col == int'(COLS) - 1) begin
        if (model_next_row()) begin e_low += 9520; e_nwr += int'(CELLS); end
      end else begin
        m_col++;
      end
    end else if (c == 7'h0A) begin
      if (model_next_row()) begin e_low = 9520; e_nwr = int'(CELLS); end
    end else if (c == 7'h0D) begin
      m_col = 0;
    end else if (c == 7'h08) begin
      if (m_col > 0) begin
        m_col--;
        e_addr = m_row * int'(COLS) + m_col;
        e_data = BLANK;
        scr[e_addr] = BLANK;
        e_low = 1; e_nwr = 1;
      end
    end else if (c == 7'h0C) begin
      model_clear();
      e_low = int'(CELLS); e_nwr = int'(CELLS);
    end
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < int'(CELLS); i++) if (mem[i] !== scr[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // Waits for ready (bounded) and performs one handshake.
  task automatic accept(input logic [7:0] ch, input logic [2:0] col);
    int w = 0;
    while (char_ready !== 1'b1 && w < 30000) begin @(negedge clk); w++; end
    check("ready_wait", 32'(char_ready), 32'd1);
    char_in = ch; color_in = col; char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    char_in = 8'($urandom);
    color_in = 3'($urandom);
  endtask

  task automatic send(input logic [7:0] ch, input logic [2:0] col);
    int low = 0;
    int nwr = 0;
    int fa = 0;
    logic [10:0] fd = '0;
    int e_low, e_nwr, e_addr;
    logic [10:0] e_data;
    accept(ch, col);
    while (char_ready !== 1'b1 && low < 30000) begin
      if (vram_wen === 1'b1) begin
        if (nwr == 0) begin fa = int'(vram_waddr); fd = vram_wdata; end
        nwr++;
      end
      low++;
      @(negedge clk);
    end
    model_step(ch, col, e_low, e_nwr, e_addr, e_data);
    check($sformatf("busy_cycles_%02h", ch), 32'(low), 32'(e_low));
    check($sformatf("writes_%02h", ch), 32'(nwr), 32'(e_nwr));
    if (e_nwr == 1) begin
      check($sformatf("waddr_%02h", ch), 32'(fa), 32'(e_addr));
      check($sformatf("wdata_%02h", ch), 32'(fd), 32'(e_data));
    end
    check($sformatf("cursor_%02h", ch), 32'(Cursor), 32'({6'(m_row), 7'(m_col)}));
    compare_mem($sformatf("vram_%02h", ch));
  endtask

  // Checks a full-screen blanking sequence starting from the current cycle.
  task automatic check_clear(input string tag);
    int w = 0;
    int bad = 0;
    while (vram_wen !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    check({tag, "_start"}, 32'(vram_wen), 32'd1);
    for (int k = 0; k < int'(CELLS); k++) begin
      if (vram_wen !== 1'b1 || vram_waddr !== 13'(k) || vram_wdata !== BLANK) bad++;
      if (char_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    check({tag, "_seq"}, 32'(bad), 32'd0);
    check({tag, "_ready"}, 32'(char_ready), 32'd1);
    check({tag, "_wen_off"}, 32'(vram_wen), 32'd0);
    check({tag, "_cursor"}, 32'(Cursor), 32'd0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return {1'($urandom), 7'($urandom_range(32'h20, 32'h7E))};
    if (r < 70) return 8'h0A;
    if (r < 76) return 8'h0D;
    if (r < 88) return 8'h08;
    if (r < 90) return 8'h0C;
    if (r < 95) return 8'h7F;
    return 8'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [7:0] rst_ch;
    rst = 1'b0;
    char_valid = 1'b0;
    char_in = '0;
    color_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_wen", 32'(vram_wen), 32'd0);
    check("rst_cursor", 32'(Cursor), 32'd0);
    check("rst_waddr", 32'(vram_waddr), 32'd0);
    check("rst_raddr", 32'(vram_raddr), 32'd0);
    check("rst_wdata", 32'(vram_wdata), 32'd0);

    rst = 1'b1;
    check_clear("clr_rst");
    model_clear();
    compare_mem("vram_after_clear");

    send(8'h41, 3'b010);
    send(8'h0A, 3'($urandom));
    send(8'h0A, 3'($urandom));
    repeat (79) send(8'($urandom_range(32'h20, 32'h7E)), 3'($urandom));
    send(8'h42, 3'b101);                       // row 2 col 79 wraps to row 3
    send(8'h0D, 3'($urandom));
    send(8'h08, 3'($urandom));                 // backspace at col 0
    repeat (3) send(8'($urandom_range(32'h20, 32'h7E)), 3'($urandom));
    send(8'h08, 3'($urandom));
    send(8'hC1, 3'b011);                       // bit 7 ignored
    while (m_row < int'(ROWS) - 1) send(8'h0A, 3'($urandom));
    repeat (5) send(8'($urandom_range(32'h20, 32'h7E)), 3'($urandom));
    send(8'h0A, 3'($urandom));                 // row overflow by newline
    while (m_row < int'(ROWS) - 1) send(8'h0A, 3'($urandom));
    repeat (80) send(8'($urandom_range(32'h20, 32'h7E)), 3'($urandom));  // overflow by wrap

    rst_ch = (SCROLL && m_row == int'(ROWS) - 1) ? 8'h0A : 8'h0C;
    accept(rst_ch, 3'd0);
    repeat (50) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_wen", 32'(vram_wen), 32'd0);
    check("abort_cursor", 32'(Cursor), 32'd0);
    check("abort_ready", 32'(char_ready), 32'd0);
    rst = 1'b1;
    check_clear("clr_abort");
    model_clear();
    compare_mem("vram_after_abort");

    send(8'h07, 3'($urandom));
    repeat (150) send(rand_byte(), 3'($urandom));

    check("wen_in_idle", 32'(idle_wen_bad), 32'd0);
    check("busy_vs_ready", 32'(busy_bad), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
